// File: rtl/ext_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pipe_pkg
//  Description : Definitions shared by decode and the registered extension
//                unit: extension mode codes and skid-buffer state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package ext_pipe_pkg;

    // Extension mode codes, carried alongside each immediate from decode.
    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    // The encoding doubles as the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } ext_state_e;

endpackage
`default_nettype wire

// File: rtl/ext_comb.sv
`default_nettype none
// ============================================================================
//  Module      : ext_comb
//  Description : Combinational immediate extender implementing the four
//                extension modes (zero, sign, upper, branch).
//  Ports       : data_in  [IN_W-1:0]  immediate to extend
//                mode     [1:0]       extension mode code
//                data_out [OUT_W-1:0] extended result
//  Revision    : 1.0  initial release
// ============================================================================
module ext_comb
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data_out
);

    localparam int c_PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_zero   = {{c_PAD_W{1'b0}}, data_in};
    assign w_sign   = {{c_PAD_W{data_in[IN_W-1]}}, data_in};
    assign w_upper  = {data_in, {c_PAD_W{1'b0}}};
    // Word offset to byte offset: drop the top two bits of the sign result.
    assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

    always_comb begin
        data_out = w_zero;
        case (mode)
            EXT_ZERO:   data_out = w_zero;
            EXT_SIGN:   data_out = w_sign;
            EXT_UPPER:  data_out = w_upper;
            EXT_BRANCH: data_out = w_branch;
            default:    data_out = w_zero;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ext_pipe
//  Description : Registered immediate extension unit with valid/ready on both
//                sides and a 2-entry skid buffer. in_ready depends only on
//                registered state, so the downstream ready path is cut.
//  Ports       : clk, rst                      clock, async active-high reset
//                in_valid/in_ready/in_data/in_mode   upstream handshake
//                out_valid/out_ready/out_data/out_neg downstream handshake
//                occupancy [1:0]               entries held (0..2)
//  Revision    : 1.0  initial release
// ============================================================================
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg,
    output logic [1:0]       occupancy
);

    generate
        if ((IN_W < 2) || (OUT_W < IN_W + 2)) begin : g_bad_params
            $error("ext_pipe: need IN_W >= 2 and OUT_W >= IN_W + 2");
        end
    endgenerate

    ext_state_e       state_q;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] skid_q;
    logic             valid_q;
    logic             rdy_en_q;
    logic [OUT_W-1:0] ext_d;
    logic             w_in_xfer;
    logic             w_out_xfer;

    ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_comb (
        .data_in  (in_data),
        .mode     (in_mode),
        .data_out (ext_d)
    );

    // rdy_en_q clears asynchronously with rst and sets on the first edge
    // after release, so in_ready is low throughout reset without rst
    // feeding any synchronous path.
    assign in_ready   = rdy_en_q && (state_q != FULL);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = valid_q && out_ready;

    assign out_valid  = valid_q;
    assign out_data   = main_q;
    assign out_neg    = main_q[OUT_W-1];
    assign occupancy  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            valid_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                EMPTY: begin
                    if (w_in_xfer) begin
                        main_q  <= ext_d;
                        valid_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        // Pass-through: main drains and refills on the same edge.
                        main_q <= ext_d;
                    end else if (w_in_xfer) begin
                        skid_q  <= ext_d;
                        state_q <= FULL;
                    end else if (w_out_xfer) begin
                        // main_q keeps its stale value; only valid drops.
                        valid_q <= 1'b0;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_pipe
//  Description : Directed self-checking bench for ext_pipe (default widths).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ext_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_passed = 0;

    ext_pipe #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] s;
        s = {{16{d[15]}}, d};
        case (m)
            2'b00:   ref_ext = {16'h0000, d};
            2'b01:   ref_ext = s;
            2'b10:   ref_ext = {d, 16'h0000};
            default: ref_ext = s * 32'd4;
        endcase
    endfunction

    // Push one word into an empty unit with out_ready=1 and check it the
    // cycle after acceptance, then let it drain.
    task automatic single(input string tag, input logic [15:0] d, input logic [1:0] m,
                          input logic [31:0] exp);
        in_valid  = 1'b1;
        in_data   = d;
        in_mode   = m;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  out_data, exp);
        chk({tag, "_neg"},   {31'd0, out_neg}, {31'd0, exp[31]});
        step();
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic [31:0] prev_data;
    logic        in_x;
    logic        out_x;
    logic        held;
    int          pushed;
    int          popped;
    int          cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_mode   = 2'b01;
        out_ready = 1'b1;

        // ---------------- reset ----------------
        step();
        step();
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_occ",       {30'd0, occupancy}, 32'd0);
        chk("rst_data",      out_data, 32'h0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        chk("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_occ",       {30'd0, occupancy}, 32'd0);

        // ---------------- mode table ----------------
        single("ffff_zero",   16'hFFFF, 2'b00, 32'h0000FFFF);
        single("ffff_sign",   16'hFFFF, 2'b01, 32'hFFFFFFFF);
        single("ffff_upper",  16'hFFFF, 2'b10, 32'hFFFF0000);
        single("ffff_branch", 16'hFFFF, 2'b11, 32'hFFFFFFFC);
        single("00aa_zero",   16'h00AA, 2'b00, 32'h000000AA);
        single("00aa_sign",   16'h00AA, 2'b01, 32'h000000AA);
        single("00aa_upper",  16'h00AA, 2'b10, 32'h00AA0000);
        single("00aa_branch", 16'h00AA, 2'b11, 32'h000002A8);
        single("8000_upper",  16'h8000, 2'b10, 32'h80000000);
        chk("stale_data", out_data, 32'h80000000);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_data   = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        in_data = 16'h0003;
        chk("bp_occ",      {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_data",     out_data, 32'h00000001);
        step();
        chk("bp_hold_occ",  {30'd0, occupancy}, 32'd2);
        chk("bp_hold_data", out_data, 32'h00000001);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_out2_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_out2_data",  out_data, 32'h00000002);
        chk("bp_out2_occ",   {30'd0, occupancy}, 32'd1);
        step();
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_empty_occ",   {30'd0, occupancy}, 32'd0);

        // ---------------- streaming, then random stalls ----------------
        pushed = 0;
        popped = 0;
        for (int phase = 0; phase < 2; phase++) begin
            for (cyc = 0; cyc < 400 && pushed < 100 * (phase + 1); cyc++) begin
                in_valid  = (phase == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                in_data   = 16'($urandom);
                in_mode   = 2'($urandom);
                out_ready = (phase == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                in_x  = in_valid && in_ready;
                out_x = out_valid && out_ready;
                held  = out_valid && !out_ready;
                prev_data = out_data;
                if (phase == 0 && cyc > 0)
                    chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
                if (phase == 0 && cyc > 0)
                    chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
                if (out_x) begin
                    exp_w = q.pop_front();
                    chk("stream_data", out_data, exp_w);
                    chk("stream_neg", {31'd0, out_neg}, {31'd0, exp_w[31]});
                    popped++;
                end
                if (in_x) begin
                    q.push_back(ref_ext(in_data, in_mode));
                    pushed++;
                end
                step();
                if (held) begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data",  out_data, prev_data);
                end
            end
            chk("stream_pushed", pushed, 100 * (phase + 1));
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int d = 0; d < 10 && out_valid; d++) begin
                exp_w = q.pop_front();
                chk("drain_data", out_data, exp_w);
                popped++;
                step();
            end
            chk("stream_popped", popped, pushed);
            chk("stream_idle", {31'd0, out_valid}, 32'd0);
        end

        // ---------------- reset while FULL ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_data   = 16'h0055;
        step();
        in_data = 16'h0066;
        step();
        in_valid = 1'b0;
        chk("full_occ", {30'd0, occupancy}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("async_rst_occ",      {30'd0, occupancy}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("async_rst_data",     out_data, 32'h0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_full_rst_valid", {31'd0, out_valid}, 32'd0);
        end
        chk("post_full_rst_occ", {30'd0, occupancy}, 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
